// File: rtl/guard_pkg.sv
// guard_pkg: shared types and defaults for the guard sprite fetch path.
//   dir_t       facing direction encoding (also the top two ROM address bits)
//   *_DEF       default geometry / animation parameters
//   rom_addr_w  sprite ROM address width for a given frame count and sprite size
package guard_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    localparam int unsigned SPRITE_W_DEF   = 32;
    localparam int unsigned SPRITE_H_DEF   = 32;
    localparam int unsigned FRAMES_DEF     = 2;
    localparam int unsigned ANIM_DIV_DEF   = 8;
    localparam int unsigned TRANSP_IDX_DEF = 0;
    localparam int unsigned COORD_W        = 10;
    localparam int unsigned PIX_W          = 4;

    // Four directions, each holding FRAMES images of w*h pixels.
    function automatic int unsigned rom_addr_w(input int unsigned frames,
                                               input int unsigned w,
                                               input int unsigned h);
        return $clog2(4 * frames * w * h);
    endfunction

endpackage

// File: rtl/guard_anim_counter.sv
// guard_anim_counter: vsync falling-edge detect and walk-animation counters.
//   Clk, Reset      clock, asynchronous active-high reset
//   vs              VGA vertical sync (active-low)
//   moving          guard is walking, sampled on each frame start
//   anim_frame      current walk-animation frame (registered)
//   frame_start_c   one-Clk pulse on the vs falling edge (combinational)
module guard_anim_counter
    import guard_pkg::*;
#(
    parameter  int unsigned FRAMES   = FRAMES_DEF,
    parameter  int unsigned ANIM_DIV = ANIM_DIV_DEF,
    localparam int unsigned FW       = (FRAMES > 1)   ? $clog2(FRAMES)   : 1,
    localparam int unsigned CW       = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          vs,
    input  logic          moving,
    output logic [FW-1:0] anim_frame,
    output logic          frame_start_c
);

    logic          vs_q,         vs_d;
    logic [CW-1:0] anim_cnt_q,   anim_cnt_d;
    logic [FW-1:0] anim_frame_q, anim_frame_d;

    // Falling edge of vs; reset value 0 keeps reset release from looking like an edge.
    assign frame_start_c = vs_q & ~vs;
    assign anim_frame    = anim_frame_q;

    // Count frames while moving; standing still restarts the walk cycle.
    always_comb begin
        vs_d         = vs;
        anim_cnt_d   = anim_cnt_q;
        anim_frame_d = anim_frame_q;
        if (frame_start_c) begin
            if (moving) begin
                anim_cnt_d = CW'(anim_cnt_q + 1'b1);
                if (anim_cnt_q == CW'(ANIM_DIV - 1)) begin
                    anim_cnt_d   = '0;
                    anim_frame_d = FW'(anim_frame_q + 1'b1);
                end
            end else begin
                anim_cnt_d   = '0;
                anim_frame_d = '0;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            vs_q         <= 1'b0;
            anim_cnt_q   <= '0;
            anim_frame_q <= '0;
        end else begin
            vs_q         <= vs_d;
            anim_cnt_q   <= anim_cnt_d;
            anim_frame_q <= anim_frame_d;
        end
    end

endmodule

// File: rtl/guard_sprite_fetch.sv
// guard_sprite_fetch: per-pixel guard sprite ROM fetch, two-Clk pipeline.
//   Clk, Reset          clock, asynchronous active-high reset
//   pix_en              pixel strobe for DrawX/DrawY
//   vs                  VGA vertical sync (active-low); falling edge latches guard state
//   DrawX, DrawY        current pixel coordinate
//   guard_x, guard_y    sprite top-left from game logic
//   dir, moving         facing direction and walking flag
//   rom_addr            registered sprite ROM address {dir, frame, row, col}
//   rom_data            ROM palette index, valid one Clk after rom_addr
//   pal_index           palette index (TRANSP_IDX outside the sprite)
//   sprite_on           pixel inside sprite and not transparent
//   out_valid           pal_index/sprite_on belong to a strobed pixel
module guard_sprite_fetch
    import guard_pkg::*;
#(
    parameter  int unsigned SPRITE_W   = SPRITE_W_DEF,
    parameter  int unsigned SPRITE_H   = SPRITE_H_DEF,
    parameter  int unsigned FRAMES     = FRAMES_DEF,
    parameter  int unsigned ANIM_DIV   = ANIM_DIV_DEF,
    parameter  int unsigned TRANSP_IDX = TRANSP_IDX_DEF,
    localparam int unsigned ROM_AW     = rom_addr_w(FRAMES, SPRITE_W, SPRITE_H)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              pix_en,
    input  logic              vs,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        guard_x,
    input  logic [9:0]        guard_y,
    input  logic [1:0]        dir,
    input  logic              moving,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [3:0]        rom_data,
    output logic [3:0]        pal_index,
    output logic              sprite_on,
    output logic              out_valid
);

    localparam int unsigned XW = $clog2(SPRITE_W);
    localparam int unsigned YW = $clog2(SPRITE_H);
    localparam int unsigned FW = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int unsigned DW = COORD_W + 1;
    localparam logic [PIX_W-1:0] TRANSP = PIX_W'(TRANSP_IDX);

    logic [FW-1:0] anim_frame;
    logic          frame_start_c;

    guard_anim_counter #(
        .FRAMES   (FRAMES),
        .ANIM_DIV (ANIM_DIV)
    ) u_anim (
        .Clk           (Clk),
        .Reset         (Reset),
        .vs            (vs),
        .moving        (moving),
        .anim_frame    (anim_frame),
        .frame_start_c (frame_start_c)
    );

    logic [COORD_W-1:0] lat_x_q,   lat_x_d;
    logic [COORD_W-1:0] lat_y_q,   lat_y_d;
    dir_t               lat_dir_q, lat_dir_d;
    logic [ROM_AW-1:0]  rom_addr_q, rom_addr_d;
    logic               v_d1_q,   v_d1_d;
    logic               hit_d1_q, hit_d1_d;
    logic               v_d2_q,   v_d2_d;
    logic               hit_d2_q, hit_d2_d;
    logic [PIX_W-1:0]   pal_index_q, pal_index_d;
    logic               sprite_on_q, sprite_on_d;
    logic               out_valid_q, out_valid_d;

    logic [DW-1:0] dx_c, dy_c;
    logic          hit_c;

    // Offset into the sprite; the extra MSB flags pixels left of / above it.
    assign dx_c  = {1'b0, DrawX} - {1'b0, lat_x_q};
    assign dy_c  = {1'b0, DrawY} - {1'b0, lat_y_q};
    assign hit_c = ~dx_c[DW-1] && (dx_c < DW'(SPRITE_W)) &&
                   ~dy_c[DW-1] && (dy_c < DW'(SPRITE_H));

    assign rom_addr  = rom_addr_q;
    assign pal_index = pal_index_q;
    assign sprite_on = sprite_on_q;
    assign out_valid = out_valid_q;

    // Frame latch, address stage, ROM-wait stage and output stage.
    always_comb begin
        lat_x_d     = lat_x_q;
        lat_y_d     = lat_y_q;
        lat_dir_d   = lat_dir_q;
        rom_addr_d  = rom_addr_q;
        v_d1_d      = pix_en;
        hit_d1_d    = pix_en & hit_c;
        v_d2_d      = v_d1_q;
        hit_d2_d    = hit_d1_q;
        pal_index_d = pal_index_q;
        sprite_on_d = sprite_on_q;
        out_valid_d = v_d2_q;

        if (frame_start_c) begin
            lat_x_d   = guard_x;
            lat_y_d   = guard_y;
            lat_dir_d = dir_t'(dir);
        end

        // A miss leaves the address alone to avoid needless ROM toggling.
        if (pix_en && hit_c) begin
            rom_addr_d = {lat_dir_q, anim_frame, dy_c[YW-1:0], dx_c[XW-1:0]};
        end

        if (v_d2_q) begin
            pal_index_d = hit_d2_q ? rom_data : TRANSP;
            sprite_on_d = hit_d2_q && (rom_data != TRANSP);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            lat_x_q     <= '0;
            lat_y_q     <= '0;
            lat_dir_q   <= DIR_UP;
            rom_addr_q  <= '0;
            v_d1_q      <= 1'b0;
            hit_d1_q    <= 1'b0;
            v_d2_q      <= 1'b0;
            hit_d2_q    <= 1'b0;
            pal_index_q <= TRANSP;
            sprite_on_q <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            lat_x_q     <= lat_x_d;
            lat_y_q     <= lat_y_d;
            lat_dir_q   <= lat_dir_d;
            rom_addr_q  <= rom_addr_d;
            v_d1_q      <= v_d1_d;
            hit_d1_q    <= hit_d1_d;
            v_d2_q      <= v_d2_d;
            hit_d2_q    <= hit_d2_d;
            pal_index_q <= pal_index_d;
            sprite_on_q <= sprite_on_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_guard_sprite_fetch.sv
// Bench for guard_sprite_fetch with a behavioural synchronous sprite ROM.
module tb_guard_sprite_fetch;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        pix_en;
    logic        vs;
    logic [9:0]  DrawX, DrawY, guard_x, guard_y;
    logic [1:0]  dir;
    logic        moving;
    logic [12:0] rom_addr;
    logic [3:0]  rom_data;
    logic [3:0]  pal_index;
    logic        sprite_on;
    logic        out_valid;

    int n_cmp  = 0;
    int n_fail = 0;

    guard_sprite_fetch dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .pix_en    (pix_en),
        .vs        (vs),
        .DrawX     (DrawX),
        .DrawY     (DrawY),
        .guard_x   (guard_x),
        .guard_y   (guard_y),
        .dir       (dir),
        .moving    (moving),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .pal_index (pal_index),
        .sprite_on (sprite_on),
        .out_valid (out_valid)
    );

    always #5 Clk = ~Clk;

    // ROM contents: a simple hash of the address, word 0 is transparent.
    function automatic logic [3:0] rom_word(input logic [12:0] a);
        return a[3:0] ^ a[7:4] ^ a[11:8];
    endfunction

    always @(posedge Clk) rom_data <= rom_word(rom_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One vs falling edge latching the given guard state.
    task automatic frame(input logic [9:0] gx, input logic [9:0] gy,
                         input logic [1:0] d, input logic mv);
        @(negedge Clk);
        guard_x = gx; guard_y = gy; dir = d; moving = mv; vs = 1'b0;
        @(negedge Clk);
        vs = 1'b1;
    endtask

    // Strobe one pixel, check the address, then the output two edges later.
    task automatic pixel(input string tag, input logic [9:0] x, input logic [9:0] y,
                         input logic [12:0] exp_addr, input logic exp_hit);
        logic [3:0] w;
        @(negedge Clk);
        DrawX = x; DrawY = y; pix_en = 1'b1;
        @(posedge Clk); #1;
        pix_en = 1'b0;
        check({tag, ".addr"}, 32'(rom_addr), 32'(exp_addr));
        @(posedge Clk);
        @(posedge Clk); #1;
        w = rom_word(exp_addr);
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".pal"}, 32'(pal_index), exp_hit ? 32'(w) : 32'd0);
        check({tag, ".on"}, 32'(sprite_on), (exp_hit && w != 4'd0) ? 32'd1 : 32'd0);
    endtask

    typedef struct {
        bit          do_frame;
        logic [9:0]  gx, gy;
        logic [1:0]  gd;
        logic [9:0]  x, y;
        logic [12:0] addr;
        bit          hit;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{1'b1, 10'd100, 10'd50,  2'd2, 10'd131, 10'd81, 13'h13FF, 1'b1};
        vecs[1] = '{1'b0, 10'd0,   10'd0,   2'd0, 10'd132, 10'd81, 13'h13FF, 1'b0};
        vecs[2] = '{1'b0, 10'd0,   10'd0,   2'd0, 10'd100, 10'd50, 13'h1000, 1'b1};
        vecs[3] = '{1'b0, 10'd0,   10'd0,   2'd0, 10'd99,  10'd50, 13'h1000, 1'b0};
        vecs[4] = '{1'b0, 10'd0,   10'd0,   2'd0, 10'd115, 10'd60, 13'h114F, 1'b1};
        vecs[5] = '{1'b0, 10'd0,   10'd0,   2'd0, 10'd100, 10'd82, 13'h114F, 1'b0};
        vecs[6] = '{1'b1, 10'd620, 10'd470, 2'd3, 10'd639, 10'd479, 13'h1933, 1'b1};
        vecs[7] = '{1'b0, 10'd0,   10'd0,   2'd0, 10'd5,   10'd5,  13'h1933, 1'b0};
        vecs[8] = '{1'b0, 10'd0,   10'd0,   2'd0, 10'd620, 10'd470, 13'h1800, 1'b1};
        vecs[9] = '{1'b0, 10'd0,   10'd0,   2'd0, 10'd0,   10'd0,  13'h1800, 1'b0};

        Reset = 1'b1; pix_en = 1'b0; vs = 1'b1;
        DrawX = '0; DrawY = '0; guard_x = '0; guard_y = '0; dir = '0; moving = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check("rst.addr",  32'(rom_addr),  32'd0);
        check("rst.pal",   32'(pal_index), 32'd0);
        check("rst.on",    32'(sprite_on), 32'd0);
        check("rst.valid", 32'(out_valid), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;

        // No vs edge yet: latches are 0, pixel (0,0) hits ROM word 0.
        pixel("origin", 10'd0, 10'd0, 13'h0000, 1'b1);
        pixel("origin31", 10'd31, 10'd31, 13'h03FF, 1'b1);

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].do_frame) frame(vecs[i].gx, vecs[i].gy, vecs[i].gd, 1'b0);
            pixel($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].addr, vecs[i].hit);
        end

        // Animation: frame bit (addr[10]) flips on every 8th moving vs edge.
        for (int i = 0; i < 7; i++) frame(10'd100, 10'd50, 2'd1, 1'b1);
        pixel("anim7", 10'd100, 10'd50, 13'h0800, 1'b1);
        frame(10'd100, 10'd50, 2'd1, 1'b1);
        pixel("anim8", 10'd100, 10'd50, 13'h0C00, 1'b1);
        for (int i = 0; i < 8; i++) frame(10'd100, 10'd50, 2'd1, 1'b1);
        pixel("anim16", 10'd100, 10'd50, 13'h0800, 1'b1);
        for (int i = 0; i < 9; i++) frame(10'd100, 10'd50, 2'd1, 1'b1);
        pixel("anim25", 10'd100, 10'd50, 13'h0C00, 1'b1);
        frame(10'd100, 10'd50, 2'd1, 1'b0);
        pixel("stop", 10'd100, 10'd50, 13'h0800, 1'b1);
        for (int i = 0; i < 7; i++) frame(10'd100, 10'd50, 2'd1, 1'b1);
        pixel("restart7", 10'd100, 10'd50, 13'h0800, 1'b1);
        frame(10'd100, 10'd50, 2'd1, 1'b1);
        pixel("restart8", 10'd100, 10'd50, 13'h0C00, 1'b1);
        frame(10'd100, 10'd50, 2'd1, 1'b0);

        // Mid-frame position change is ignored until the next vs edge.
        @(negedge Clk);
        guard_x = 10'd300;
        pixel("midframe", 10'd100, 10'd50, 13'h0800, 1'b1);
        frame(10'd300, 10'd50, 2'd1, 1'b0);
        pixel("newframe", 10'd100, 10'd50, 13'h0800, 1'b0);
        frame(10'd100, 10'd50, 2'd1, 1'b0);
        pixel("pre_coin", 10'd101, 10'd50, 13'h0801, 1'b1);

        // vs edge on the same Clk as a pixel: the pixel uses the old latches.
        @(negedge Clk);
        guard_x = 10'd200; dir = 2'd2; vs = 1'b0;
        DrawX = 10'd100; DrawY = 10'd50; pix_en = 1'b1;
        @(posedge Clk); #1;
        pix_en = 1'b0; vs = 1'b1;
        check("coincide.addr", 32'(rom_addr), 32'h0800);
        pixel("post_coin", 10'd200, 10'd50, 13'h1000, 1'b1);

        // Reset with two pixels in flight and a visible output.
        frame(10'd100, 10'd50, 2'd2, 1'b0);
        @(negedge Clk);
        DrawX = 10'd131; DrawY = 10'd81; pix_en = 1'b1;
        @(negedge Clk);
        DrawX = 10'd115; DrawY = 10'd60;
        @(negedge Clk);
        DrawX = 10'd131; DrawY = 10'd81;
        @(posedge Clk); #1;
        pix_en = 1'b0;
        check("pre_rst.on", 32'(sprite_on), 32'd1);
        Reset = 1'b1;
        #1;
        check("async_rst.valid", 32'(out_valid), 32'd0);
        check("async_rst.on",    32'(sprite_on), 32'd0);
        check("async_rst.addr",  32'(rom_addr),  32'd0);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge Clk); #1;
            check($sformatf("flush%0d.valid", i), 32'(out_valid), 32'd0);
        end
        pixel("post_rst", 10'd0, 10'd0, 13'h0000, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/guard_sprite_fetch.md
# guard_sprite_fetch

Per-pixel sprite fetch stage for the guard character. Takes the VGA controller's draw coordinates and the guard's game-state position, direction and motion flag, and produces the synchronous sprite-ROM address. It then emits the 4-bit palette index and a sprite-hit flag, aligned two clocks later. It sits directly upstream of the guard palette lookup, which converts the index to 12-bit RGB, and in parallel with the background path feeding the colour mapper.

## Interface
- SPRITE_W, 32, sprite width in pixels (power of two)
- SPRITE_H, 32, sprite height in pixels (power of two)
- FRAMES, 2, walk-animation frames per direction (power of two)
- ANIM_DIV, 8, vsync frames per animation step while moving
- TRANSP_IDX, 0, palette index treated as transparent
- Clk  input  1  system clock; all state on rising edge
- Reset  input  1  asynchronous, active-high; clears all state
- pix_en  input  1  pixel strobe; one Clk-wide pulse per DrawX/DrawY pixel
- vs  input  1  VGA vertical sync, active-low
- DrawX, DrawY  input  10 each  current pixel coordinate from VGA controller
- guard_x, guard_y  input  10 each  sprite top-left from game logic
- dir  input  2  facing direction: 0 up, 1 down, 2 left, 3 right
- moving  input  1  guard is walking
- rom_addr  output  log2(4*FRAMES*SPRITE_W*SPRITE_H) (13 at defaults)  sprite ROM address
- rom_data  input  4  ROM palette index; valid one Clk after rom_addr is registered
- pal_index  output  4  palette index to downstream palette
- sprite_on  output  1  pixel is inside sprite and not transparent
- out_valid  output  1  pal_index/sprite_on correspond to a strobed pixel

## Operation
- Frame latch: falling edge of vs detected synchronously (vs registered once, edge = prev & ~vs). On edge: lat_x, lat_y, lat_dir, lat_moving <= inputs. The fetch uses only the latched values, so no mid-frame tearing. Reset value of all latches is 0.
- Animation: anim_cnt (log2(ANIM_DIV) bits) and anim_frame (log2(FRAMES) bits).
  - On each vs edge with moving=1: anim_cnt increments. On wrap to 0, anim_frame increments modulo FRAMES.
  - On a vs edge with moving=0: both counters are cleared to 0.
  - A dir change does not reset the animation.
- Hit test: dx = {1'b0,DrawX} - {1'b0,lat_x} and dy likewise, both 11-bit. hit = (dx[10]==0 && dx < SPRITE_W) && (dy[10]==0 && dy < SPRITE_H).
  - A sprite extending past x=639 or y=479 simply clips.
  - A coordinate left of or above the sprite gives negative dx/dy, i.e. a miss.
- Address: rom_addr = {lat_dir, anim_frame, dy[log2 H-1:0], dx[log2 W-1:0]}. On a miss, rom_addr holds its previous value.
- Output: on a hit, pal_index = rom_data and sprite_on = (rom_data != TRANSP_IDX). On a miss, pal_index = TRANSP_IDX and sprite_on = 0.

## Timing
- Stage 1 (Clk edge with pix_en=1): rom_addr, hit_d1 and v_d1 (set to 1) are registered. On an edge with pix_en=0, v_d1 <= 0.
- ROM cycle: rom_data is valid after the next edge. hit_d2 <= hit_d1 and v_d2 <= v_d1.
- Stage 2: pal_index, sprite_on and out_valid are registered from rom_data, hit_d2 and v_d2.
- Latency is 2 Clk edges from the pix_en sample to the output. Throughput is one pixel per Clk; back-to-back pix_en is legal.
- Outputs hold their value between valid pixels.
- Reset values: rom_addr=0, pal_index=TRANSP_IDX, sprite_on=0, out_valid=0, and all pipeline valid/hit bits 0.
- Reset mid-frame: the pipeline flushes immediately. The first valid output is 2 Clk after the first pix_en following Reset deassertion. Latched position stays 0 until the next vs edge.
- A vs edge coinciding with pix_en: the pixel in flight uses the pre-edge latches, and the new latches apply from the next pix_en.

## Structure
- Shared package guard_pkg:
  - dir_t enum (DIR_UP=0, DIR_DOWN, DIR_LEFT, DIR_RIGHT)
  - SPRITE_W/SPRITE_H/FRAMES defaults
  - ROM address-width localparam function
- One sub-module, guard_anim_counter: vs edge detect plus anim_cnt/anim_frame. Outputs are anim_frame and the frame_start pulse, which also drives the position latch.
- The ROM is external and instantiated alongside this block and the palette.

## Test plan
- After Reset, no vs edge, pix_en at DrawX=0, DrawY=0 -> rom_addr=0. out_valid=1 at 2 Clk; pal_index equals the ROM word 0, and sprite_on=0 iff that word is TRANSP_IDX.
- Latch guard (100,50), dir=2, moving=0; strobe (131,81) -> rom_addr = {2'd2,1'b0,5'd31,5'd31} = 0x13FF. Strobe (132,81) -> sprite_on=0, pal_index=0.
- Guard at (620,470); strobe (639,479) hit with rom_addr col=19, row=9. Strobe (5,5) -> miss; no wrap-around false hit.
- moving=1 for 8 vs edges -> anim_frame 0->1 on the 8th. 16 edges -> back to 0. Drop moving for one edge -> anim_frame=0 and anim_cnt=0.
- Change guard_x mid-frame without a vs edge -> addresses unchanged until the next vs falling edge.
- Assert Reset while 2 pixels are in flight -> out_valid=0 and sprite_on=0 immediately (asynchronous). No stale output after release.
